// File: rtl/hex_keypad_scanner.sv
// Scans a 4x4 hex keypad (COL drive / ROW sense), debounces, and shifts accepted digits into value_out.
// Latency: accept lands 1 cycle after the last slot of the DEBOUNCE_SCANS-th matching scan (scan = 4*SCAN_DIV cycles).
// Backpressure: none, key_valid is a bare one-cycle pulse; define KEYPAD_AUTOREPEAT_EN for auto-repeat while held.
module hex_keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ROW,
    input  logic        clear,
    output logic [3:0]  COL,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [15:0] value_out
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_SCANS - 1);

    // Elaboration-time guard on parameter ranges.
    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_check
        $error("hex_keypad_scanner: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        col_idx;
    logic              last_slot;
    logic              scan_done;

    logic [3:0]        row_meta;
    logic [3:0]        row_sync;

    logic [2:0]        col_hits;
    logic [1:0]        col_row;
    logic [3:0]        col_code;

    logic [1:0]        acc_hits;
    logic [3:0]        acc_code;
    logic [2:0]        hit_sum;
    logic [1:0]        tot_hits;
    logic [3:0]        tot_code;

    logic              res_none;
    logic              res_single;
    logic [3:0]        res_code;
    logic [15:0]       accept_value;

    state_t            state;
    logic [3:0]        cand;
    logic [CNT_W-1:0]  cnt;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
    logic [REP_W-1:0]  rep_cnt;
`endif

    // Keypad legend indexed by row and column.
    function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'h0;
            4'b11_01: k = 4'hF;
            4'b11_10: k = 4'hE;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    assign last_slot = (slot_cnt == SLOT_LAST);
    assign scan_done = last_slot && (col_idx == 2'd3);

    // Slot timer and column walker; COL rotates its single low bit on each wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt <= '0;
            col_idx  <= 2'd0;
            COL      <= 4'b1110;
        end else if (last_slot) begin
            slot_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            COL      <= {COL[2:0], COL[3]};
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Two-flop synchronizer for the asynchronous row inputs; idle level is all-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= ROW;
            row_sync <= row_meta;
        end
    end

    // Count low rows in the current column and remember which one (only meaningful for one hit).
    always_comb begin
        col_hits = 3'd0;
        col_row  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync[r]) begin
                col_hits = col_hits + 3'd1;
                col_row  = 2'(r);
            end
        end
    end

    assign col_code = key_of(col_row, col_idx);

    // Merge this column into the running scan tally; hit counts saturate at 2 (= MULTI).
    always_comb begin
        hit_sum  = {1'b0, acc_hits} + col_hits;
        tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        tot_code = (acc_hits == 2'd0) ? col_code : acc_code;
    end

    assign res_none   = (tot_hits == 2'd0);
    assign res_single = (tot_hits == 2'd1);
    assign res_code   = tot_code;

    // Every accept shifts in the scan's single code; a coincident clear keeps only that digit.
    assign accept_value = clear ? {12'h000, res_code} : {value_out[11:0], res_code};

    // Scan tally: accumulate per column, restart after the column-3 evaluation.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_hits <= 2'd0;
            acc_code <= 4'h0;
        end else if (last_slot) begin
            if (col_idx == 2'd3) begin
                acc_hits <= 2'd0;
                acc_code <= 4'h0;
            end else begin
                acc_hits <= tot_hits;
                acc_code <= tot_code;
            end
        end
    end

    // Debounce / hold / release FSM with registered key outputs and entry register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= 4'h0;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            key_held  <= 1'b0;
            value_out <= 16'h0000;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (clear) begin
                value_out <= 16'h0000;
            end
            if (scan_done) begin
                case (state)
                    IDLE: begin
                        if (res_single) begin
                            cand <= res_code;
                            if (DEBOUNCE_SCANS == 1) begin
                                state     <= PRESSED;
                                cnt       <= '0;
                                key_valid <= 1'b1;
                                key_code  <= res_code;
                                key_held  <= 1'b1;
                                value_out <= accept_value;
                            end else begin
                                state <= DEBOUNCE;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    DEBOUNCE: begin
                        // A different single key breaks the run; it starts counting next scan.
                        if (res_single && (res_code == cand)) begin
                            if (cnt == CNT_LAST) begin
                                state     <= PRESSED;
                                cnt       <= '0;
                                key_valid <= 1'b1;
                                key_code  <= res_code;
                                key_held  <= 1'b1;
                                value_out <= accept_value;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (res_none) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                state    <= IDLE;
                                cnt      <= '0;
                                key_held <= 1'b0;
                            end else begin
                                state <= RELEASE;
                                cnt   <= CNT_W'(1);
                            end
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        // The only way out of PRESSED is a NONE scan, which zeroes rep_cnt,
                        // so every entry into PRESSED starts the repeat count from zero.
                        if (res_single && (res_code == key_code)) begin
                            if (rep_cnt == REP_LAST) begin
                                rep_cnt   <= '0;
                                key_valid <= 1'b1;
                                key_code  <= res_code;
                                value_out <= accept_value;
                            end else begin
                                rep_cnt <= rep_cnt + REP_W'(1);
                            end
                        end else begin
                            rep_cnt <= '0;
                        end
`endif
                    end
                    RELEASE: begin
                        if (res_none) begin
                            if (cnt == CNT_LAST) begin
                                state    <= IDLE;
                                cnt      <= '0;
                                key_held <= 1'b0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else begin
                            // Contact came back before release settled: still the same press.
                            state <= PRESSED;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/hex_keypad_scanner.md
Name: hex_keypad_scanner

Overview:
- Scans a 4x4 matrix hex keypad by driving columns and reading rows, which is the input-side counterpart of the multiplexed seven-segment display output.
- Debounces key presses and emits one 4-bit hex code per press.
- Shifts accepted digits into a 16-bit entry register, which feeds the display data input directly.
- Sits between the keypad connector pins and user logic / seven_segment_driver.

Parameters:
- SCAN_DIV, 100000: clock cycles each column stays driven (1 ms at 100 MHz); legal range ≥ 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results needed to accept a press or a release; legal range ≥ 1.
- REPEAT_SCANS, 250: full scans between auto-repeats; used only with the optional feature.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- ROW  input  4  keypad rows; active-low, pulled up externally; asynchronous to clk.
- clear  input  1  synchronous clear of value_out.
- COL  output  4  keypad column drive; active-low, exactly one bit low at any time.
- key_valid  output  1  one-cycle pulse when a debounced key is accepted.
- key_code  output  4  hex code of the last accepted key; held between pulses.
- key_held  output  1  high while an accepted key remains pressed.
- value_out  output  16  last four accepted digits; newest digit in [3:0].

Behaviour:
- Clocking and reset:
  - One clock domain; reset is synchronous and active-high.
  - Reset values: COL=4'b1110, key_valid=0, key_code=0, key_held=0, value_out=16'h0000.
  - Reset also clears all counters and the synchronizer, and puts the FSM in IDLE.
  - Reset mid-press returns to IDLE. The held key is then re-debounced from scratch and accepted as a new press.
- Column scan:
  - Slot counter counts 0..SCAN_DIV-1, then wraps and advances the column index 0→1→2→3→0.
  - COL drives column c low: c0=1110, c1=1101, c2=1011, c3=0111.
- Row sampling:
  - ROW passes through a 2-flop synchronizer.
  - Synchronized rows are sampled on the last slot cycle of each column, giving SCAN_DIV-1 cycles of settling.
- Key map (row r, column c, rows/columns numbered 0..3):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Scan result, evaluated once per full scan on the last slot cycle of column 3:
  - NONE: no low row sample across all 4 columns.
  - SINGLE(code): exactly one low sample.
  - MULTI: two or more low samples, including ghosting.
- FSM (transitions take effect at scan-result evaluation; cnt counts matching scans):
  - IDLE: SINGLE(k) → DEBOUNCE, cand=k, cnt=1. NONE or MULTI → stay.
  - DEBOUNCE, checked when cnt<DEBOUNCE_SCANS:
    - SINGLE(cand) → cnt+1.
    - Anything else → IDLE.
  - DEBOUNCE, when cnt reaches DEBOUNCE_SCANS → PRESSED.
    - With DEBOUNCE_SCANS=1, acceptance occurs directly from IDLE.
  - PRESSED: key_held=1. NONE → RELEASE, cnt=1. SINGLE or MULTI → stay (no new key while held).
  - RELEASE:
    - NONE → cnt+1.
    - NONE with cnt reaching DEBOUNCE_SCANS → IDLE, key_held=0.
    - SINGLE or MULTI → PRESSED, cnt reset, no new pulse.
- Accept action:
  - Registered on the clock edge after the evaluating cycle.
  - key_valid=1 for exactly one cycle; key_code=cand.
  - value_out updates to {value_out[11:0], cand}; the oldest digit is dropped with no saturation.
  - key_held rises in the same cycle as key_valid.
- clear:
  - Sets value_out=0 on the next edge.
  - If clear coincides with an accept: value_out={12'h000, cand}.
  - clear does not affect the FSM, key_code, or key_held.
- Latency: acceptance happens at the end of the DEBOUNCE_SCANS-th consecutive identical scan, plus 1 cycle.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter increments once per full scan while the result is SINGLE(key_code).
  - At REPEAT_SCANS it issues an accept action (key_valid pulse plus shift) and the counter restarts.
  - The counter clears on entering PRESSED or on any MULTI or NONE result.
- Undefined:
  - Exactly one key_valid per press; the repeat logic is absent.

Test Plan:
Bench settings: SCAN_DIV=8, DEBOUNCE_SCANS=3, REPEAT_SCANS=4; one full scan = 32 cycles.
1. Assert reset 2 cycles with ROW=4'hF → COL=1110, all outputs 0. COL then steps 1101, 1011, 0111 at 8-cycle intervals, and returns to 1110 at cycle 32.
2. Hold key '5' (ROW[1] low whenever COL[1] low) for 6 scans → single key_valid pulse 1 cycle after the end of scan 3; key_code=5, value_out=16'h0005, key_held=1. key_held stays 1 until 3 NONE scans after release.
3. Press/release keys 1,2,3,A and then 7, each held 4 scans and released 4 scans → 5 pulses; value_out ends at 16'h23A7.
4. Bounce: key '9' present 2 scans, absent 1, present 2, then absent → no key_valid, value_out unchanged.
5. Press '1' and '2' simultaneously for 5 scans → no pulse (MULTI). Then release '2' → '1' accepted after 3 scans. Assert clear in that accept cycle → value_out=16'h0001.
6. Reset asserted mid-DEBOUNCE of 'F' while still pressed → outputs cleared. 'F' is re-accepted 3 scans after reset deasserts; value_out=16'h000F. With KEYPAD_AUTOREPEAT_EN, 'F' held 11 more scans after acceptance gives 2 extra pulses → value_out=16'h0FFF.
